// File: rtl/ee357_mdu.sv
// Iterative MIPS HI/LO unit: 32-step shift-add multiply / restoring divide plus HI/LO moves.
// Latency: moves and divide-by-zero finish the cycle after accept, mul/div 34 cycles; starts are ignored while busy.
module ee357_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [5:0]       func,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      cnt;
  logic               op_div;
  logic               neg_main;
  logic               neg_rem;

  logic               supported, is_md, is_div, signed_op, div_zero, accept, go_run;
  logic [WIDTH-1:0]   a_abs, b_abs;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_r;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    supported = (func[5:2] == 4'b0100) || (func[5:2] == 4'b0110);
    is_md     = (func[5:2] == 4'b0110);
    is_div    = is_md && func[1];
    signed_op = is_md && !func[0];
    div_zero  = is_div && (opb == '0);
    accept    = (state == IDLE) && start && supported;
    go_run    = accept && is_md && !div_zero;
    a_abs     = (signed_op && opa[WIDTH-1]) ? -opa : opa;
    b_abs     = (signed_op && opb[WIDTH-1]) ? -opb : opb;

    // Multiply: acc = {partial product, remaining multiplier bits}
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    div_r    = acc[2*WIDTH-1:WIDTH-1];
    div_ok   = div_r >= {1'b0, mcand};
    div_sub  = div_r[WIDTH-1:0] - mcand;
    div_next = div_ok ? {div_sub, acc[WIDTH-2:0], 1'b1}
                      : {div_r[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    prod_fix = neg_main ? -acc : acc;
    quo_fix  = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_run) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      mcand    <= '0;
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res      <= '0;
      hi       <= '0;
      lo       <= '0;
      dz       <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (accept && !go_run) || (state == FIX);
      if (accept) begin
        dz <= div_zero;
        case (func)
          F_MTHI:  hi  <= opa;
          F_MTLO:  lo  <= opa;
          F_MFHI:  res <= hi;
          F_MFLO:  res <= lo;
          default: ;
        endcase
      end
      if (go_run) begin
        acc      <= {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
        mcand    <= is_div ? b_abs : a_abs;
        cnt      <= '0;
        op_div   <= is_div;
        neg_main <= signed_op && (opa[WIDTH-1] ^ opb[WIDTH-1]);
        neg_rem  <= signed_op && opa[WIDTH-1];
      end
      if (state == RUN) begin
        acc <= op_div ? div_next : mul_next;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        if (op_div) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_ee357_mdu.sv
// Bench for ee357_mdu: directed cases plus random ops against an arithmetic HI/LO model.
module tb_ee357_mdu;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] opa, opb;
  logic [5:0]  func;
  logic        busy, done, dz;
  logic [31:0] res, hi, lo;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] m_hi, m_lo, m_res;
  logic        m_dz;

  ee357_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .opa(opa), .opb(opb), .func(func),
    .busy(busy), .done(done), .res(res), .hi(hi), .lo(lo), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: plain signed/unsigned arithmetic on the architectural registers.
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p, q, r;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_dz = 1'b0;
    case (f)
      F_MTHI: m_hi = a;
      F_MTLO: m_lo = a;
      F_MFHI: m_res = m_hi;
      F_MFLO: m_res = m_lo;
      F_MULT: begin
        p = sa * sb;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      F_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      F_DIV: begin
        if (b == 0) m_dz = 1'b1;
        else begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      F_DIVU: begin
        if (b == 0) m_dz = 1'b1;
        else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit mid_pulse);
    bit long_op;
    int exp_lat, first, ndone, nbusy;
    long_op = (f[5:2] == 4'b0110) && !(f[1] && b == 0);
    exp_lat = long_op ? 34 : 1;
    first = 0; ndone = 0; nbusy = 0;
    @(negedge clk);
    start = 1'b1; func = f; opa = a; opb = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    opa = $urandom;
    opb = $urandom;
    for (int k = 1; k <= exp_lat + 2; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first == 0) first = k;
      end
      if (busy) nbusy++;
      if (mid_pulse && k == 5) begin
        start = 1'b1; func = F_MFLO;
      end
      if (k == 6) start = 1'b0;
    end
    model(f, a, b);
    chk("done_latency", first, exp_lat);
    chk("done_count", ndone, 1);
    chk("busy_cycles", nbusy, long_op ? 33 : 0);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("res", res, m_res);
    chk("dz", {31'b0, dz}, {31'b0, m_dz});
  endtask

  logic [5:0] funcs [8];
  int ndone_rst;

  initial begin
    funcs = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
    rst = 1'b1; start = 1'b0; opa = '0; opb = '0; func = '0;
    m_hi = '0; m_lo = '0; m_res = '0; m_dz = 1'b0;
    #3;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_res", res, 32'h0);
    chk("rst_busy_done_dz", {29'b0, busy, done, dz}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op(F_MULTU, 32'hffffffff, 32'hffffffff, 0);
    chk("multu_hi_const", hi, 32'hfffffffe);
    chk("multu_lo_const", lo, 32'h00000001);
    run_op(F_MULT, 32'hffffffff, 32'h00000002, 0);
    chk("mult_neg_hi", hi, 32'hffffffff);
    chk("mult_neg_lo", lo, 32'hfffffffe);
    run_op(F_MULT, 32'h7fffffff, 32'h7fffffff, 0);
    chk("mult_max_hi", hi, 32'h3fffffff);
    chk("mult_max_lo", lo, 32'h00000001);
    run_op(F_DIV, 32'hfffffff9, 32'h00000002, 0);
    chk("div_lo", lo, 32'hfffffffd);
    chk("div_hi", hi, 32'hffffffff);
    run_op(F_DIVU, 32'hfffffff9, 32'h00000002, 0);
    chk("divu_lo", lo, 32'h7ffffffc);
    chk("divu_hi", hi, 32'h00000001);
    run_op(F_DIV, 32'h80000000, 32'hffffffff, 0);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'h00000000);
    run_op(F_DIVU, 32'd5, 32'd0, 0);
    chk("dz_flag", {31'b0, dz}, 32'd1);

    run_op(F_MTHI, 32'h12345678, 32'h0, 0);
    run_op(F_MTLO, 32'h9abcdef0, 32'h0, 0);
    // MFHI then MFLO on consecutive edges
    @(negedge clk);
    start = 1'b1; func = F_MFHI;
    @(negedge clk);
    chk("mfhi_res", res, 32'h12345678);
    chk("mfhi_done", {31'b0, done}, 32'd1);
    func = F_MFLO;
    @(negedge clk);
    start = 1'b0;
    chk("mflo_res", res, 32'h9abcdef0);
    chk("mflo_done", {31'b0, done}, 32'd1);
    m_res = 32'h9abcdef0;
    @(negedge clk);
    chk("move_done_drop", {31'b0, done}, 32'd0);

    // MFLO pulsed mid-multiply must be dropped
    run_op(F_MULT, 32'h00001234, 32'hffff0000, 1);
    chk("mid_start_res", res, 32'h9abcdef0);

    // Unsupported func
    @(negedge clk);
    start = 1'b1; func = 6'b100000; opa = 32'hdeadbeef;
    ndone_rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done || busy) ndone_rst++;
    end
    chk("bad_func_quiet", ndone_rst, 0);
    chk("bad_func_hi", hi, m_hi);

    // Reset 10 cycles into a MULTU
    @(negedge clk);
    start = 1'b1; func = F_MULTU; opa = 32'hffffffff; opb = 32'hffffffff;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_res", res, 32'h0);
    chk("arst_busy_done_dz", {29'b0, busy, done, dz}, 32'h0);
    m_hi = '0; m_lo = '0; m_res = '0; m_dz = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ndone_rst = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone_rst++;
    end
    chk("no_done_after_rst", ndone_rst, 0);
    run_op(F_MULTU, 32'd3, 32'd4, 0);
    chk("post_rst_lo", lo, 32'd12);

    // Random ops against the model
    for (int i = 0; i < 30; i++) begin
      logic [5:0]  f;
      logic [31:0] a, b;
      f = funcs[$urandom_range(7)];
      a = $urandom;
      b = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(3) == 0) a = {$urandom_range(1) == 1 ? 1'b1 : 1'b0, 31'h0};
      run_op(f, a, b, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ee357_mdu.md
# ee357_mdu

Iterative multiply/divide unit that answers the same `opa`/`opb`/`func` operand interface as the single-cycle ALU. It handles the MIPS HI/LO instruction group: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. The multicycle CPU controller issues an operation with `start`, stalls on `busy`, and takes the result on `done`. The block owns the architectural HI and LO registers.

## Interface
- `WIDTH`, default 32: operand and register width. Only 32 is supported; the iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  issue strobe; sampled only in IDLE.
- `opa`  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- `opb`  in  32  rt operand: multiplier or divisor.
- `func`  in  6  R-type funct code:
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011
- `busy`  out  1  high while a multiply/divide iterates.
- `done`  out  1  one-cycle completion pulse.
- `res`  out  32  registered MFHI/MFLO read data.
- `hi`, `lo`  out  32 each  architectural HI/LO contents.
- `dz`  out  1  divide-by-zero flag of the last accepted DIV/DIVU.

## Operation
- States: IDLE, RUN, FIX.
- Accept edge E0: `start`=1 in IDLE with a supported `func`. Any other `func` with `start` is ignored: no state change and no `done`.
- At any accept, `dz` is cleared unless the op is a divide by zero.
- MTHI / MTLO:
  - At E0: `hi` (or `lo`) <= `opa`.
  - `done`=1 for the cycle after E0; `busy` stays 0.
- MFHI / MFLO:
  - At E0: `res` <= `hi` (or `lo`).
  - `done`=1 for the cycle after E0.
- DIV / DIVU with `opb`=0:
  - At E0: `dz` <= 1; `hi`/`lo` unchanged.
  - `done` pulses the cycle after E0; no RUN.
- MULT / MULTU / DIV / DIVU (non-zero divisor), at E0:
  - Latch operand magnitudes: two's-complement absolute value for MULT/DIV, raw value for U variants.
  - Latch the sign-fix bits.
  - Counter <= 0; state <= RUN.
- RUN, edges E1..E32, one iteration per edge:
  - Multiply: 64-bit shift-add.
  - Divide: restoring shift-subtract, one quotient bit per edge.
  - After the 32nd iteration, state <= FIX.
- FIX, edge E33:
  - MULT: negate the 64-bit product if operand signs differ.
  - DIV: negate the quotient if signs differ; negate the remainder if the dividend is negative.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Write `hi` = product[63:32] or remainder, `lo` = product[31:0] or quotient.
  - `done` <= 1; state <= IDLE.
- Widths:
  - Magnitude of 0x80000000 is 0x80000000 unsigned.
  - DIV 0x80000000 / 0xffffffff yields `lo`=0x80000000, `hi`=0 with no trap and no flag.
- `start` during RUN/FIX is ignored and is not queued.
- `res` holds its value except on MFHI/MFLO accepts.
- Operand inputs may change after E0 without affecting the running op.

## Timing
- Reset values: state IDLE; `hi`, `lo`, `res` = 0; `busy`, `done`, `dz` = 0.
- `rst` asserted mid-operation aborts immediately. Partial results are discarded and no `done` follows.
- `busy` is registered: high from after E0 to after E33, i.e. 33 cycles.
- Multiply/divide: `hi`/`lo` update and `done`=1 in the cycle after E33. A new `start` may be accepted on that same edge (E34).
- Single-cycle ops: result and `done` valid in the cycle after E0. Back-to-back accepts on consecutive edges are allowed.
- `done` is never high for more than one consecutive cycle per accepted op.
- MFHI accepted on the same edge as the FIX write reads the pre-write value. That case cannot occur, because starts are ignored in FIX.

## Test plan
- MULTU: `opa`=`opb`=0xffffffff.
  - Required: `hi`=0xfffffffe, `lo`=0x00000001; `busy` high for exactly 33 cycles; `done` 34 edges after E0.
- MULT: 0xffffffff × 0x00000002.
  - Required: `hi`=0xffffffff, `lo`=0xfffffffe.
  - Then MULT 0x7fffffff × 0x7fffffff: `hi`=0x3fffffff, `lo`=0x00000001.
- DIV: 0xfffffff9 / 0x00000002.
  - Required: `lo`=0xfffffffd, `hi`=0xffffffff.
  - DIVU with the same operands: `lo`=0x7ffffffc, `hi`=0x00000001.
- Edge divides:
  - DIV 0x80000000 / 0xffffffff: `lo`=0x80000000, `hi`=0, `dz`=0.
  - DIVU 5 / 0: `dz`=1, `done` the cycle after E0, `hi`/`lo` unchanged.
- Moves and ignored starts:
  - MTHI 0x12345678, MTLO 0x9abcdef0, MFHI then MFLO on consecutive edges: `res`=0x12345678 then 0x9abcdef0.
  - `start` with MFLO pulsed mid-MULT: ignored, `res` unchanged.
  - `start` with `func`=100000: no `done`.
- Reset mid-operation: assert `rst` 10 cycles into a MULTU.
  - Required: all outputs 0 asynchronously; no `done` afterwards.
  - A subsequent MULTU 3 × 4 gives `hi`=0, `lo`=12.
